// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory stage with a req/resp handshake and programmable wait states.
// Supports LOAD, STORE, scatter-store SSTORE and atomic SWAP, with range and alignment reporting.
module data_mem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 128,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_STORE  = 2'd1,
    OP_SSTORE = 2'd2,
    OP_SWAP   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // The whole word index is compared, so high address bits can never alias into the array.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-3:0] widx;
    widx     = addr[ADDR_W-1:2];
    addr_err = (addr[1:0] != 2'b00) || (widx >= (ADDR_W-2)'(DEPTH));
  endfunction

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  // Words never written since power-up read back as their own index.
  logic [DEPTH-1:0]    written_q = '0;

  logic [IDX_W-1:0]    acc_idx_s;
  logic                acc_err_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic                mem_we_s;

  assign acc_idx_s = addr_q[IDX_W+1:2];

  // Access-cycle decode: error flag and current contents of the addressed word.
  always_comb begin
    acc_err_s = addr_err(addr_q);
    if (written_q[acc_idx_s]) begin
      rd_word_s = mem_q[acc_idx_s];
    end else begin
      rd_word_s = DATA_W'(acc_idx_s);
    end
  end

  // Next-state and datapath decode for the request/response sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d = op_e'(req_op);
          if (op_e'(req_op) == OP_SSTORE) begin
            addr_d = ADDR_W'(req_wdata);
            data_d = DATA_W'(req_addr);
          end else begin
            addr_d = req_addr;
            data_d = req_wdata;
          end
          if (WAIT_CYC > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        err_d   = acc_err_s;
        if (acc_err_s) begin
          rdata_d = '0;
        end else begin
          mem_we_s = (op_q != OP_LOAD);
          case (op_q)
            OP_LOAD, OP_SWAP: rdata_d = rd_word_s;
            default:          rdata_d = '0;
          endcase
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
    busy_d  = (state_d != ST_IDLE);
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_LOAD;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Storage write port; contents survive rst, and a reset on the access edge blocks the write.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[acc_idx_s]     <= data_q;
      written_q[acc_idx_s] <= 1'b1;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the memory stage.
module tb_data_mem_ctrl;

  localparam int WAIT  = 2;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYC(WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 idle, 1 in flight, 2 response pending.
  logic [31:0] mmem [DEPTH];
  int          m_phase = 0;
  int          m_left  = 0;
  logic [1:0]  m_op;
  logic [31:0] m_addr, m_data;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err   = 1'b0;
  logic        m_rst   = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = i;
  end

  always @(posedge clk) begin
    m_rst = rst;
    if (rst) begin
      m_phase = 0;
      m_rdata = 32'd0;
      m_err   = 1'b0;
    end else if (m_phase == 0) begin
      if (req_valid) begin
        m_op    = req_op;
        m_addr  = (req_op == 2'd2) ? req_wdata : req_addr;
        m_data  = (req_op == 2'd2) ? req_addr  : req_wdata;
        m_left  = WAIT + 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin
        if (m_addr[1:0] != 2'b00 || (m_addr >> 2) >= DEPTH) begin
          m_err   = 1'b1;
          m_rdata = 32'd0;
        end else begin
          m_err   = 1'b0;
          m_rdata = (m_op == 2'd0 || m_op == 2'd3) ? mmem[m_addr >> 2] : 32'd0;
          if (m_op != 2'd0) mmem[m_addr >> 2] = m_data;
        end
        m_phase = 2;
      end
    end else if (resp_ready) begin
      m_phase = 0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    chk("req_ready", {31'd0, req_ready}, {31'd0, m_phase == 0});
    chk("busy", {31'd0, busy}, {31'd0, m_phase != 0});
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_phase == 2});
    if (m_phase == 2 || m_rst) begin
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] w,
                       input int hold, output logic [31:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w;
    @(posedge clk); #1;
    lat = 0;
    while (!resp_valid && lat <= 40) begin
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 2'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
    rd = resp_rdata;
    er = resp_err;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] w, input int hold,
                          input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_op(op, a, w, hold, rd, er, lat);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, {31'd0, er}, {31'd0, exp_er});
    chk({nm, "_lat"}, lat, WAIT + 1);
  endtask

  // Accept a request, then assert rst for the k-th edge after acceptance.
  task automatic rst_mid(input logic [1:0] op, input logic [31:0] a, input logic [31:0] w,
                         input int k);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (k - 1) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, a, w;
    logic        er;
    logic [1:0]  op;
    int          lat, r;

    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = 32'd0; req_wdata = 32'd0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);

    check_op("t1_load10", 2'd0, 32'h10, 32'h0, 0, 32'd4, 1'b0);
    check_op("t2_store20", 2'd1, 32'h20, 32'hDEADBEEF, 5, 32'd0, 1'b0);
    check_op("t2_load20", 2'd0, 32'h20, 32'h0, 1, 32'hDEADBEEF, 1'b0);
    check_op("t3_sstore", 2'd2, 32'h55, 32'h40, 0, 32'd0, 1'b0);
    check_op("t3_load40", 2'd0, 32'h40, 32'h0, 0, 32'h55, 1'b0);
    check_op("t3_load54", 2'd0, 32'h54, 32'h0, 0, 32'd21, 1'b0);
    check_op("t4_swap0c", 2'd3, 32'h0C, 32'h99, 2, 32'd3, 1'b0);
    check_op("t4_load0c", 2'd0, 32'h0C, 32'h0, 0, 32'h99, 1'b0);
    check_op("t5_load13", 2'd0, 32'h13, 32'h0, 0, 32'd0, 1'b1);
    check_op("t5_store200", 2'd1, 32'h200, 32'h1, 0, 32'd0, 1'b1);
    check_op("t5_load00", 2'd0, 32'h00, 32'h0, 0, 32'd0, 1'b0);
    check_op("t5_load1fc", 2'd0, 32'h1FC, 32'h0, 0, 32'd127, 1'b0);
    check_op("t5_store_hi", 2'd1, 32'h8000_0000, 32'h7, 0, 32'd0, 1'b1);
    check_op("t5_load_hi0", 2'd0, 32'h00, 32'h0, 0, 32'd0, 1'b0);
    rst_mid(2'd1, 32'h08, 32'hAA, 1);
    check_op("t6_load08_a", 2'd0, 32'h08, 32'h0, 0, 32'd2, 1'b0);
    rst_mid(2'd1, 32'h08, 32'hAA, WAIT + 1);
    check_op("t6_load08_b", 2'd0, 32'h08, 32'h0, 0, 32'd2, 1'b0);

    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 15);
      a  = 32'($urandom_range(0, DEPTH + 3)) << 2;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = a | 32'h8000_0000;
      w  = $urandom;
      op = 2'($urandom);
      if (r == 2) begin
        rst_mid(op, (op == 2'd2) ? w : a, (op == 2'd2) ? a : w, $urandom_range(1, WAIT + 2));
      end else if (op == 2'd2) begin
        do_op(op, w, a, $urandom_range(0, 3), rd, er, lat);
      end else begin
        do_op(op, a, w, $urandom_range(0, 3), rd, er, lat);
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      check_op("final_sweep", 2'd0, 32'(i) << 2, 32'h0, 0, mmem[i], 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
